serial_shift_sequencer: RTL and testbench
=========================================

// Module: serial_shift_sequencer
// PURPOSE
//  Controller and datapath for parallel-in/serial-out transmission of one WIDTH-bit word, MSB first.
//  Accepts a word on a start pulse when idle and loads it into an n-bit shift register.
//  Sequences WIDTH shift steps, with an optional pause, then signals completion for one cycle.
//  Sits between a word producer and a bit-serial consumer in the shift-register lab datapath.
// PARAMETERS
//  WIDTH   8                  word length in bits; WIDTH >= 2
//  CNT_W   $clog2(WIDTH)      bit-counter width; derived, do not override
// PORTS
//  clk         in   1      single clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request to transmit data_in; honoured only in IDLE
//  data_in     in   WIDTH  word captured on the edge where start is accepted
//  pause       in   1      1 = hold the current bit (no shift, no count) while in SHIFT
//  sout        out  1      serial bit = shift register MSB
//  sout_valid  out  1      1 while in SHIFT (sout carries a word bit)
//  busy        out  1      1 in SHIFT or DONE; start ignored while busy
//  done        out  1      1-cycle pulse after the last bit
//  bit_cnt     out  CNT_W  index of the bit currently on sout (0 = MSB)
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, shift reg=0, bit_cnt=0; sout=0, sout_valid=0, busy=0, done=0.
//    Reset has priority over all other inputs, including mid-word; an aborted word never raises done.
//  - FSM states:
//    IDLE:  start=1 -> load data_in into the shift reg, bit_cnt=0, go to SHIFT.
//           start=0 -> stay; shift reg holds.
//    SHIFT: pause=1 -> hold everything.
//           pause=0 and bit_cnt<WIDTH-1 -> shift left 1 with 0 fill, bit_cnt+1.
//           pause=0 and bit_cnt==WIDTH-1 -> shift, bit_cnt=0, go to DONE.
//    DONE:  done=1 for exactly this cycle; unconditionally go to IDLE. start and pause are ignored.
//  - Latency: with no pause, the first bit is on sout the cycle after the accept edge.
//    sout_valid stays high for WIDTH cycles, done is high in cycle WIDTH+1, and state is IDLE in cycle WIDTH+2.
//  - Each pause cycle in SHIFT adds exactly one cycle. pause is don't-care outside SHIFT.
//  - start held high continuously: a new word is accepted on every IDLE cycle, so there is one idle cycle between words.
//  - sout, sout_valid, busy, done and bit_cnt are decoded from registered state only; there is no combinational input->output path.
//  - Captured data is fixed at load; data_in changes while busy have no effect.
// STRUCTURE
//  - serial_shift_defs.vh: localparams for the 2-bit state encodings S_IDLE=0, S_SHIFT=1, S_DONE=2, shared with the benches.
//  - Sub-module nbit_shift_reg #(WIDTH): ports clk, rst, ld, sh, d, q.
//    Synchronous clear on rst; ld has priority over sh; sh = left shift with 0 in.
//  - Top level holds the FSM and bit counter and drives ld/sh; sout = q[WIDTH-1].
// TESTING (WIDTH=8, 200 ns clock period)
//  1 rst=1 for 2 edges, then idle -> sout=0, sout_valid=0, busy=0, done=0, bit_cnt=0.
//  2 start pulse with data_in=8'b10110100 -> sout=1,0,1,1,0,1,0,0 over 8 cycles with sout_valid=1.
//    done=1 in cycle 9, busy=0 in cycle 10.
//  3 same word, pause=1 for 2 cycles while bit_cnt=2 -> sout=1 held 3 cycles, bit_cnt stays 2.
//    done appears in cycle 11.
//  4 start with data_in=8'd175 asserted mid-word -> ignored, first word completes unchanged.
//    start in IDLE with 8'd175 -> 1,0,1,0,1,1,1,1.
//  5 rst=1 at the edge after bit 4 -> next cycle IDLE, sout_valid=0, busy=0.
//    done never pulses for that word.
//  6 start held high for 25 cycles, data_in=8'hA5 -> two complete words.
//    done pulses exactly 2 times, with one busy=0 cycle between the words.

Source files
------------

// File: rtl/serial_shift_sequencer_pkg.sv
// Shared constants for the serial shift sequencer: FSM state encodings and a
// bit-counter helper.
package serial_shift_sequencer_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // True when the counter points at the final (LSB) bit of a WIDTH-bit word.
  function automatic logic is_last_bit(input int unsigned cnt, input int unsigned width);
    return cnt == (width - 1);
  endfunction

endpackage

// File: rtl/serial_shift_sequencer_if.sv
// Producer/consumer bus for the serial shift sequencer: word request in,
// serial bit stream and status out.
interface serial_shift_sequencer_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             pause;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output start, data_in, pause,
    input  sout, sout_valid, busy, done, bit_cnt
  );

  modport slave (
    input  start, data_in, pause,
    output sout, sout_valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/serial_shift_sequencer_nbit_shift_reg.sv
// WIDTH-bit parallel-load register with left shift and zero fill.
// Load wins over shift when both are requested.
module nbit_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
    else if (sh) q <= {q[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/serial_shift_sequencer.sv
// Parallel-in/serial-out sequencer: loads a word on start, shifts it out MSB
// first with optional pause, then pulses done for one cycle.
module serial_shift_sequencer
  import serial_shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  serial_shift_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             ld;
  logic             sh;
  logic             last;

  assign ld   = (state == S_IDLE) && bus.start;
  assign sh   = (state == S_SHIFT) && !bus.pause;
  assign last = is_last_bit(32'(cnt), WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_SHIFT;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          if (!bus.pause) begin
            if (last) begin
              state <= S_DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  nbit_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .sh  (sh),
    .d   (bus.data_in),
    .q   (q)
  );

  // All outputs decode registered state only; no input reaches them combinationally.
  assign bus.sout       = q[WIDTH-1];
  assign bus.sout_valid = (state == S_SHIFT);
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.bit_cnt    = cnt;

endmodule

// File: tb/tb_serial_shift_sequencer.sv
// Bench for serial_shift_sequencer: directed scenarios followed by random
// traffic, with a word-level reference model feeding a per-cycle scoreboard.
module tb_serial_shift_sequencer;

  localparam int W = 8;

  typedef struct {
    bit       sout;
    bit       vld;
    bit       busy;
    bit       done;
    bit [2:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #100 clk = ~clk;

  serial_shift_sequencer_if #(.WIDTH(W)) bus ();

  serial_shift_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   done_seen = 0;

  // Reference model: a word is either absent, being sent at bit position idx,
  // or just finished. Outputs are derived from that description directly.
  bit       m_valid_ref = 0;
  bit       m_sending   = 0;
  bit       m_finished  = 0;
  int       m_idx       = 0;
  bit [7:0] m_word      = 0;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_valid_ref = 1;
      m_sending   = 0;
      m_finished  = 0;
      m_idx       = 0;
    end else if (m_finished) begin
      m_finished = 0;
    end else if (m_sending) begin
      if (!bus.pause) begin
        if (m_idx == W - 1) begin
          m_sending  = 0;
          m_finished = 1;
          m_idx      = 0;
        end else begin
          m_idx++;
        end
      end
    end else if (bus.start) begin
      m_word    = bus.data_in;
      m_sending = 1;
      m_idx     = 0;
    end
    if (m_valid_ref) begin
      e.sout = m_sending ? m_word[W-1-m_idx] : 1'b0;
      e.vld  = m_sending;
      e.busy = m_sending || m_finished;
      e.done = m_finished;
      e.cnt  = m_sending ? 3'(m_idx) : 3'd0;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected record per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.sout !== e.sout || bus.sout_valid !== e.vld || bus.busy !== e.busy ||
          bus.done !== e.done || bus.bit_cnt !== e.cnt) begin
        fails++;
        $display("FAIL outputs @%0t: got sout=%b vld=%b busy=%b done=%b cnt=%0d, want sout=%b vld=%b busy=%b done=%b cnt=%0d",
                 $time, bus.sout, bus.sout_valid, bus.busy, bus.done, bus.bit_cnt,
                 e.sout, e.vld, e.busy, e.done, e.cnt);
      end
      if (bus.done === 1'b1) done_seen++;
    end
  end

  // Drive one cycle's inputs, then advance to the next falling edge.
  task automatic cyc(input bit s, input bit [7:0] d, input bit p, input bit r);
    bus.start   = s;
    bus.data_in = d;
    bus.pause   = p;
    rst         = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
  endtask

  initial begin
    int  dc;
    bit [7:0] rd;
    bus.start = 0; bus.data_in = 0; bus.pause = 0; rst = 1;
    @(negedge clk);
    // 1: reset for two edges, then idle
    cyc(0, 8'h00, 0, 1);
    idle(3);
    // 2: plain word
    cyc(1, 8'b1011_0100, 0, 0);
    idle(11);
    // 3: pause two cycles at bit_cnt=2
    cyc(1, 8'b1011_0100, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    idle(10);
    // 4: start mid-word ignored, then accepted in idle
    cyc(1, 8'b1011_0100, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'd175, 0, 0);
    idle(7);
    cyc(1, 8'd175, 0, 0);
    idle(11);
    // 5: reset after bit 4 aborts the word
    cyc(1, 8'b1011_0100, 0, 0);
    idle(4);
    cyc(0, 8'h00, 0, 1);
    idle(12);
    // 6: start held for 25 cycles -> exactly two done pulses
    dc = done_seen;
    for (int i = 0; i < 25; i++) cyc(1, 8'hA5, 0, 0);
    tests++;
    if (done_seen - dc != 2) begin
      fails++;
      $display("FAIL done_count: got %0d, want 2", done_seen - dc);
    end
    // random traffic: start, pause, data and occasional reset
    for (int i = 0; i < 600; i++) begin
      rd = 8'($urandom);
      cyc($urandom_range(0, 3) == 0, rd, $urandom_range(0, 3) == 0,
          $urandom_range(0, 79) == 0);
    end
    idle(14);
    @(negedge clk);
    tests++;
    if (exp_q.size() > 1) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want <=1", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
